// File: rtl/mcdf_fifo_defs.sv
// Shared constants for the multi-channel data formatter FIFOs: default
// geometry and the read-mode encodings.
package mcdf_fifo_defs;

  localparam int FIFO_DEPTH_DEF    = 8;
  localparam int FIFO_WIDE_DEF     = 32;
  localparam int FIFO_PTR_WIDE_DEF = 3;

  typedef enum logic {
    FIFO_MODE_REG  = 1'b0,
    FIFO_MODE_FWFT = 1'b1
  } fifo_mode_e;

endpackage

// File: rtl/fifo_wm_mem.sv
// FIFO storage array: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module fifo_wm_mem
  import mcdf_fifo_defs::*;
#(
  parameter int WIDE     = FIFO_WIDE_DEF,
  parameter int PTR_WIDE = FIFO_PTR_WIDE_DEF
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [PTR_WIDE-1:0] wr_addr,
  input  logic [WIDE-1:0]     wr_data,
  input  logic [PTR_WIDE-1:0] rd_addr,
  output logic [WIDE-1:0]     rd_data
);

  logic [WIDE-1:0] mem_q [2**PTR_WIDE];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fifo_wm.sv
// Channel FIFO with watermark flags, occupancy count, sticky overflow/underflow
// flags and selectable registered or first-word-fall-through read mode.
module fifo_wm
  import mcdf_fifo_defs::*;
#(
  parameter int FIFO_DEPTH    = FIFO_DEPTH_DEF,
  parameter int FIFO_WIDE     = FIFO_WIDE_DEF,
  parameter int FIFO_PTR_WIDE = FIFO_PTR_WIDE_DEF,
  parameter bit FWFT          = FIFO_MODE_REG
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fifo_en,
  input  logic                     fifo_wr_en,
  input  logic                     fifo_rd_en,
  input  logic [FIFO_WIDE-1:0]     fifo_data_in,
  input  logic [FIFO_PTR_WIDE:0]   afull_thr,
  input  logic [FIFO_PTR_WIDE:0]   aempty_thr,
  input  logic                     err_clr,
  output logic [FIFO_WIDE-1:0]     fifo_data_out,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic [FIFO_PTR_WIDE:0]   fifo_level,
  output logic [FIFO_PTR_WIDE:0]   fifo_slack,
  output logic                     fifo_afull,
  output logic                     fifo_aempty,
  output logic                     fifo_uplink_ready,
  output logic                     fifo_downlink_ready,
  output logic                     fifo_ovf,
  output logic                     fifo_udf
);

  localparam int LVL_W = FIFO_PTR_WIDE + 1;
  localparam logic [LVL_W-1:0]         DEPTH_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0]         LVL_ONE   = LVL_W'(1);
  localparam logic [FIFO_PTR_WIDE-1:0] PTR_ONE   = FIFO_PTR_WIDE'(1);

  if (FIFO_DEPTH != (1 << FIFO_PTR_WIDE)) begin : g_depth_check
    $error("fifo_wm: FIFO_DEPTH must equal 2**FIFO_PTR_WIDE");
  end

  logic [FIFO_PTR_WIDE-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_PTR_WIDE-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]         level_q, level_d;
  logic                     ovf_q, ovf_d;
  logic                     udf_q, udf_d;
  logic                     wr_accept, rd_accept;
  logic [FIFO_WIDE-1:0]     mem_rd_data;

  // Flags decode from the level register only, so requests never reach them.
  assign fifo_full           = (level_q == DEPTH_LVL);
  assign fifo_empty          = (level_q == '0);
  assign fifo_level          = level_q;
  assign fifo_slack          = DEPTH_LVL - level_q;
  assign fifo_afull          = (level_q >= afull_thr);
  assign fifo_aempty         = (level_q <= aempty_thr);
  assign fifo_uplink_ready   = fifo_en && !fifo_full;
  assign fifo_downlink_ready = fifo_en && !fifo_empty;
  assign fifo_ovf            = ovf_q;
  assign fifo_udf            = udf_q;

  assign wr_accept = fifo_en && fifo_wr_en && !fifo_full;
  assign rd_accept = fifo_en && fifo_rd_en && !fifo_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;

    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (wr_accept && !rd_accept) begin
      level_d = level_q + LVL_ONE;
    end else if (rd_accept && !wr_accept) begin
      level_d = level_q - LVL_ONE;
    end

    // A disabled block freezes everything, the error flags included; a new
    // error in the same cycle as err_clr must survive the clear.
    if (fifo_en) begin
      if (err_clr) begin
        ovf_d = 1'b0;
        udf_d = 1'b0;
      end
      if (fifo_wr_en && fifo_full) begin
        ovf_d = 1'b1;
      end
      if (fifo_rd_en && fifo_empty) begin
        udf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_wm_mem #(
    .WIDE     (FIFO_WIDE),
    .PTR_WIDE (FIFO_PTR_WIDE)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr_q),
    .wr_data (fifo_data_in),
    .rd_addr (rd_ptr_q),
    .rd_data (mem_rd_data)
  );

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    // Head entry is shown directly; zero when nothing valid is stored.
    assign fifo_data_out = fifo_empty ? '0 : mem_rd_data;
  end else begin : g_reg
    logic [FIFO_WIDE-1:0] dout_q, dout_d;

    always_comb begin
      dout_d = dout_q;
      if (rd_accept) begin
        dout_d = mem_rd_data;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_q <= '0;
      end else begin
        dout_q <= dout_d;
      end
    end

    assign fifo_data_out = dout_q;
  end

endmodule

// File: tb/tb_fifo_wm.sv
// Directed bench for fifo_wm: a registered-read and an FWFT instance share
// all inputs so the two read modes can be compared on the same traffic.
module tb_fifo_wm;

  logic        clk;
  logic        rst_n;
  logic        fifo_en;
  logic        fifo_wr_en;
  logic        fifo_rd_en;
  logic [31:0] fifo_data_in;
  logic [3:0]  afull_thr;
  logic [3:0]  aempty_thr;
  logic        err_clr;

  logic [31:0] r_dout, f_dout;
  logic        r_full, r_empty, r_afull, r_aempty, r_upr, r_dnr, r_ovf, r_udf;
  logic        f_full, f_empty, f_afull, f_aempty, f_upr, f_dnr, f_ovf, f_udf;
  logic [3:0]  r_level, r_slack, f_level, f_slack;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_wm #(.FIFO_DEPTH(8), .FIFO_WIDE(32), .FIFO_PTR_WIDE(3), .FWFT(1'b0)) u_dut_reg (
    .clk                 (clk),
    .rst_n               (rst_n),
    .fifo_en             (fifo_en),
    .fifo_wr_en          (fifo_wr_en),
    .fifo_rd_en          (fifo_rd_en),
    .fifo_data_in        (fifo_data_in),
    .afull_thr           (afull_thr),
    .aempty_thr          (aempty_thr),
    .err_clr             (err_clr),
    .fifo_data_out       (r_dout),
    .fifo_full           (r_full),
    .fifo_empty          (r_empty),
    .fifo_level          (r_level),
    .fifo_slack          (r_slack),
    .fifo_afull          (r_afull),
    .fifo_aempty         (r_aempty),
    .fifo_uplink_ready   (r_upr),
    .fifo_downlink_ready (r_dnr),
    .fifo_ovf            (r_ovf),
    .fifo_udf            (r_udf)
  );

  fifo_wm #(.FIFO_DEPTH(8), .FIFO_WIDE(32), .FIFO_PTR_WIDE(3), .FWFT(1'b1)) u_dut_fwft (
    .clk                 (clk),
    .rst_n               (rst_n),
    .fifo_en             (fifo_en),
    .fifo_wr_en          (fifo_wr_en),
    .fifo_rd_en          (fifo_rd_en),
    .fifo_data_in        (fifo_data_in),
    .afull_thr           (afull_thr),
    .aempty_thr          (aempty_thr),
    .err_clr             (err_clr),
    .fifo_data_out       (f_dout),
    .fifo_full           (f_full),
    .fifo_empty          (f_empty),
    .fifo_level          (f_level),
    .fifo_slack          (f_slack),
    .fifo_afull          (f_afull),
    .fifo_aempty         (f_aempty),
    .fifo_uplink_ready   (f_upr),
    .fifo_downlink_ready (f_dnr),
    .fifo_ovf            (f_ovf),
    .fifo_udf            (f_udf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock of traffic; outputs are sampled 1 time unit after the edge.
  task automatic applyStimulus(input logic wr, input logic rd, input logic clr,
                               input logic [31:0] din);
    fifo_wr_en   = wr;
    fifo_rd_en   = rd;
    err_clr      = clr;
    fifo_data_in = din;
    @(posedge clk);
    #1;
    fifo_wr_en = 1'b0;
    fifo_rd_en = 1'b0;
    err_clr    = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    fifo_en      = 1'b1;
    fifo_wr_en   = 1'b0;
    fifo_rd_en   = 1'b0;
    fifo_data_in = '0;
    afull_thr    = 4'd6;
    aempty_thr   = 4'd1;
    err_clr      = 1'b0;
    #2;

    $display("[TB] reset state");
    checkOutput("rst_level",  32'(r_level), 32'd0);
    checkOutput("rst_empty",  32'(r_empty), 32'd1);
    checkOutput("rst_full",   32'(r_full),  32'd0);
    checkOutput("rst_slack",  32'(r_slack), 32'd8);
    checkOutput("rst_aempty", 32'(r_aempty), 32'd1);
    checkOutput("rst_afull",  32'(r_afull), 32'd0);
    checkOutput("rst_upr",    32'(r_upr),   32'd1);
    checkOutput("rst_dnr",    32'(r_dnr),   32'd0);
    checkOutput("rst_dout",   r_dout,       32'd0);
    checkOutput("rst_ovf",    32'(r_ovf),   32'd0);
    checkOutput("rst_udf",    32'(r_udf),   32'd0);
    checkOutput("rst_fdout",  f_dout,       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] fill 1..8 with watermark sweep");
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'(i));
      checkOutput("fill_level",  32'(r_level),  32'(i));
      checkOutput("fill_aempty", 32'(r_aempty), (i <= 1) ? 32'd1 : 32'd0);
      checkOutput("fill_afull",  32'(r_afull),  (i >= 6) ? 32'd1 : 32'd0);
    end
    checkOutput("full_flag",  32'(r_full),  32'd1);
    checkOutput("full_slack", 32'(r_slack), 32'd0);
    checkOutput("full_upr",   32'(r_upr),   32'd0);
    checkOutput("full_dnr",   32'(r_dnr),   32'd1);

    $display("[TB] drain 8, registered read");
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
      checkOutput("drain_dout", r_dout, 32'(i));
    end
    checkOutput("drain_empty", 32'(r_empty), 32'd1);
    checkOutput("drain_slack", 32'(r_slack), 32'd8);
    checkOutput("drain_udf",   32'(r_udf),   32'd0);

    $display("[TB] wrap-around at half occupancy");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'(100 + i));
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'(104 + k));
      checkOutput("wrap_dout",  r_dout,       32'(100 + k));
      checkOutput("wrap_level", 32'(r_level), 32'd4);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
      checkOutput("wrap_tail", r_dout, 32'(120 + i));
    end
    checkOutput("wrap_empty", 32'(r_empty), 32'd1);

    $display("[TB] simultaneous read/write while full");
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'(200 + i));
    applyStimulus(1'b1, 1'b1, 1'b0, 32'hDEAD);
    checkOutput("rwfull_level", 32'(r_level), 32'd7);
    checkOutput("rwfull_ovf",   32'(r_ovf),   32'd1);
    checkOutput("rwfull_dout",  r_dout,       32'd200);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd0);
    checkOutput("ovf_clr", 32'(r_ovf), 32'd0);
    for (int i = 1; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
      checkOutput("rwfull_drain", r_dout, 32'(200 + i));
    end
    checkOutput("rwfull_empty", 32'(r_empty), 32'd1);

    $display("[TB] underflow and err_clr");
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("udf_set",   32'(r_udf),   32'd1);
    checkOutput("udf_level", 32'(r_level), 32'd0);
    checkOutput("udf_dout",  r_dout,       32'd207);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd0);
    checkOutput("udf_clr", 32'(r_udf), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'd0);
    checkOutput("udf_set_wins", 32'(r_udf), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd0);
    checkOutput("udf_clr2", 32'(r_udf), 32'd0);

    $display("[TB] threshold change");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'(48 + i));
    checkOutput("thr_afull_lvl4", 32'(r_afull), 32'd0);
    afull_thr = 4'd3;
    #1;
    checkOutput("thr_afull_now", 32'(r_afull), 32'd1);
    afull_thr = 4'd6;
    #1;
    checkOutput("thr_afull_back", 32'(r_afull), 32'd0);

    $display("[TB] enable low freezes state");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'(52 + i));
    checkOutput("en_full", 32'(r_full), 32'd1);
    fifo_en = 1'b0;
    #1;
    checkOutput("en_upr", 32'(r_upr), 32'd0);
    checkOutput("en_dnr", 32'(r_dnr), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'hBEEF);
    checkOutput("en_level", 32'(r_level), 32'd8);
    checkOutput("en_ovf",   32'(r_ovf),   32'd0);
    checkOutput("en_dout",  r_dout,       32'd207);
    fifo_en = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("en_resume", r_dout, 32'd48);

    $display("[TB] FWFT and asynchronous reset");
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("fwft_empty0", f_dout, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'hA5);
    checkOutput("fwft_head",   f_dout, 32'hA5);
    checkOutput("fwft_regout", r_dout, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'hB6);
    checkOutput("fwft_pop",      f_dout, 32'hB6);
    checkOutput("fwft_reg_pop",  r_dout, 32'hA5);
    checkOutput("fwft_level",    32'(f_level), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'hC1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'hC2);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_empty", 32'(f_empty), 32'd1);
    checkOutput("arst_level", 32'(f_level), 32'd0);
    checkOutput("arst_fdout", f_dout,       32'd0);
    checkOutput("arst_rdout", r_dout,       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'hC7);
    checkOutput("post_rst_head",  f_dout,       32'hC7);
    checkOutput("post_rst_level", 32'(f_level), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("post_rst_read",  r_dout,       32'hC7);
    checkOutput("post_rst_empty", 32'(f_empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
